// File: rtl/chacha_stream_sequencer.sv
// Sequences one ChaCha ENCRYPT (opcode 0x08) transaction between the SPI byte link and the cipher core.
// Optional idle watchdog is compiled in when STREAM_TIMEOUT_EN is defined; otherwise o_timeout is 0.
module chacha_stream_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_TX_Ready,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic       o_start,
  output logic [7:0] o_plaintext,
  output logic       o_plain_valid,
  input  logic       i_plain_ready,
  input  logic [7:0] i_cyphertext,
  input  logic       i_cypher_valid,
  output logic       o_cypher_ready,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] OP_ENCRYPT = 8'h08;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN    = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  rx_cnt_q, rx_cnt_d;
  logic [8:0]  tx_cnt_q, tx_cnt_d;
  logic [AW:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [AW:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        overflow_q, overflow_d;

  logic [7:0]  in_mem  [FIFO_DEPTH];
  logic [7:0]  out_mem [FIFO_DEPTH];

  logic        in_empty, in_full, out_empty, out_full;
  logic        in_push, in_pop, out_push, out_pop;
  logic        in_stream, rx_take, rx_drop, flush, wd_fire;
  logic [7:0]  in_head, out_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[AW] != in_rd_q[AW]) && (in_wr_q[AW-1:0] == in_rd_q[AW-1:0]);
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[AW] != out_rd_q[AW]) && (out_wr_q[AW-1:0] == out_rd_q[AW-1:0]);
  assign in_head   = in_mem[in_rd_q[AW-1:0]];
  assign out_head  = out_mem[out_rd_q[AW-1:0]];

  assign in_stream = (state_q == ST_STREAM);
  assign in_pop    = !in_empty && i_plain_ready;
  assign rx_take   = in_stream && i_RX_DV && (rx_cnt_q < len_q);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign in_push   = rx_take && (!in_full || in_pop);
  assign rx_drop   = rx_take && in_full && !in_pop;
  assign out_push  = i_cypher_valid && o_cypher_ready;
  assign out_pop   = in_stream && !out_empty && i_TX_Ready && !tx_dv_q;
  assign flush     = wd_fire || (state_q == ST_LEN);

  assign o_plain_valid  = !in_empty;
  assign o_plaintext    = in_empty ? 8'h00 : in_head;
  assign o_cypher_ready = in_stream && !out_full;
  assign o_TX_DV        = tx_dv_q;
  assign o_TX_Byte      = tx_byte_q;
  assign o_start        = (state_q == ST_START);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_overflow     = overflow_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (i_RX_DV && (i_RX_Byte == OP_ENCRYPT)) begin
          state_d    = ST_LEN;
          overflow_d = 1'b0;
        end
      end
      ST_LEN: begin
        if (i_RX_DV) begin
          // A length byte of zero encodes 256.
          len_d    = {(i_RX_Byte == 8'h00), i_RX_Byte};
          rx_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: state_d = ST_STREAM;
      ST_STREAM: begin
        if (rx_take) rx_cnt_d = rx_cnt_q + 9'd1;
        if (rx_drop) overflow_d = 1'b1;
        if (out_pop) begin
          tx_cnt_d = tx_cnt_q + 9'd1;
          if ((tx_cnt_q + 9'd1) == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (wd_fire) state_d = ST_IDLE;
  end

  always_comb begin
    in_wr_d   = in_push  ? (in_wr_q + PTR_ONE)  : in_wr_q;
    in_rd_d   = in_pop   ? (in_rd_q + PTR_ONE)  : in_rd_q;
    out_wr_d  = out_push ? (out_wr_q + PTR_ONE) : out_wr_q;
    out_rd_d  = out_pop  ? (out_rd_q + PTR_ONE) : out_rd_q;
    if (flush) begin
      in_wr_d  = '0;
      in_rd_d  = '0;
      out_wr_d = '0;
      out_rd_d = '0;
    end
    tx_dv_d   = out_pop;
    tx_byte_d = out_pop ? out_head : tx_byte_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_Clk) begin
    if (in_push)  in_mem[in_wr_q[AW-1:0]]   <= i_RX_Byte;
    if (out_push) out_mem[out_wr_q[AW-1:0]] <= i_cyphertext;
  end

`ifdef STREAM_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    wd_d      = '0;
    wd_fire   = 1'b0;
    timeout_d = timeout_q;
    if ((state_q == ST_IDLE) && i_RX_DV && (i_RX_Byte == OP_ENCRYPT)) timeout_d = 1'b0;
    // Any RX byte, core handshake or TX pulse counts as progress.
    if ((state_q == ST_LEN) || in_stream) begin
      if (!(i_RX_DV || in_pop || out_pop)) begin
        if (wd_q == WD_LAST) begin
          wd_fire   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule
